uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 35 +++
 rtl/uart_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART upload framer and its receive-side parser.
// Holds the state encoding, sync bytes, frame overhead and checksum helpers.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_CMD,
        ST_LENH,
        ST_LENL,
        ST_PLD,
        ST_CSUM
    } frame_state_t;

    localparam logic [7:0]  HDR0_DEF       = 8'hAA;
    localparam logic [7:0]  HDR1_DEF       = 8'h55;
    localparam logic [7:0]  PAD_BYTE_DEF   = 8'h00;
    localparam logic [15:0] MAX_LEN_DEF    = 16'd4096;
    localparam logic [23:0] TIMEOUT_DEF    = 24'd2_500_000;
    localparam int          FRAME_OVERHEAD = 6;

    // Running sum wraps at 8 bits; the transmitted byte is its complement.
    function automatic logic [7:0] csum_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

    function automatic logic [7:0] csum_final(input logic [7:0] acc);
        return ~acc;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Upload framer: wraps cmd/len/payload into AA 55 cmd lenH lenL data.. csum
// and streams the bytes into uart_top through a registered valid/ready slot.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter logic [15:0] MAX_LEN        = MAX_LEN_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [7:0]  PAD_BYTE       = PAD_BYTE_DEF,
    parameter logic [7:0]  HDR0           = HDR0_DEF,
    parameter logic [7:0]  HDR1           = HDR1_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    input  logic [7:0]  frame_cmd,
    input  logic [15:0] frame_len,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_err,
    input  logic [7:0]  pld_data,
    input  logic        pld_valid,
    output logic        pld_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    frame_state_t state, state_nx;

    logic [7:0]  cmd_q, cmd_nx;
    logic [15:0] len_q, len_nx;
    logic [15:0] rem, rem_nx;
    logic [7:0]  csum, csum_nx;
    logic [23:0] starve, starve_nx;
    logic        pad, pad_nx;
    logic        busy_nx, done_nx, err_nx;
    logic        ld;
    logic [7:0]  byte_nx;
    logic        valid_nx;
    logic        slot_free;

    assign slot_free = !tx_valid || tx_ready;
    assign pld_ready = (state == ST_PLD) && slot_free
                       && (rem != 16'd0) && !pad;

    always_comb begin
        state_nx  = state;
        cmd_nx    = cmd_q;
        len_nx    = len_q;
        rem_nx    = rem;
        csum_nx   = csum;
        starve_nx = starve;
        pad_nx    = pad;
        busy_nx   = frame_busy;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        ld        = 1'b0;
        byte_nx   = tx_data;

        unique case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    if (frame_len > MAX_LEN) begin
                        err_nx = 1'b1;
                    end else begin
                        cmd_nx  = frame_cmd;
                        len_nx  = frame_len;
                        busy_nx = 1'b1;
                        csum_nx = csum_add(csum_add(frame_cmd,
                                  frame_len[15:8]), frame_len[7:0]);
                        // Slot may still hold the previous csum byte.
                        if (slot_free) begin
                            ld       = 1'b1;
                            byte_nx  = HDR0;
                            state_nx = ST_SYNC1;
                        end else begin
                            state_nx = ST_SYNC0;
                        end
                    end
                end
            end
            ST_SYNC0: begin
                if (slot_free) begin
                    ld       = 1'b1;
                    byte_nx  = HDR0;
                    state_nx = ST_SYNC1;
                end
            end
            ST_SYNC1: begin
                if (slot_free) begin
                    ld       = 1'b1;
                    byte_nx  = HDR1;
                    state_nx = ST_CMD;
                end
            end
            ST_CMD: begin
                if (slot_free) begin
                    ld       = 1'b1;
                    byte_nx  = cmd_q;
                    state_nx = ST_LENH;
                end
            end
            ST_LENH: begin
                if (slot_free) begin
                    ld       = 1'b1;
                    byte_nx  = len_q[15:8];
                    state_nx = ST_LENL;
                end
            end
            ST_LENL: begin
                if (slot_free) begin
                    ld        = 1'b1;
                    byte_nx   = len_q[7:0];
                    rem_nx    = len_q;
                    starve_nx = 24'd0;
                    pad_nx    = 1'b0;
                    state_nx  = (len_q == 16'd0) ? ST_CSUM : ST_PLD;
                end
            end
            ST_PLD: begin
                if (slot_free) begin
                    if (pad || pld_valid) begin
                        ld      = 1'b1;
                        byte_nx = pad ? PAD_BYTE : pld_data;
                        csum_nx = csum_add(csum, byte_nx);
                        rem_nx  = rem - 16'd1;
                        if (!pad) begin
                            starve_nx = 24'd0;
                        end
                        if (rem == 16'd1) begin
                            state_nx = ST_CSUM;
                        end
                    end else if (starve != TIMEOUT_CYCLES) begin
                        starve_nx = starve + 24'd1;
                        if (starve_nx == TIMEOUT_CYCLES) begin
                            pad_nx = 1'b1;
                            err_nx = 1'b1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (slot_free) begin
                    ld       = 1'b1;
                    byte_nx  = csum_final(csum);
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign valid_nx = ld || (tx_valid && !tx_ready);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= 8'd0;
            len_q      <= 16'd0;
            rem        <= 16'd0;
            csum       <= 8'd0;
            starve     <= 24'd0;
            pad        <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            cmd_q      <= cmd_nx;
            len_q      <= len_nx;
            rem        <= rem_nx;
            csum       <= csum_nx;
            starve     <= starve_nx;
            pad        <= pad_nx;
            frame_busy <= busy_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
            tx_data    <= byte_nx;
            tx_valid   <= valid_nx;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected tx bytes are queued at
// stimulus time and popped on every tx_valid && tx_ready handshake.
module tb_uart_frame_tx;

    localparam logic [23:0] TO = 24'd100;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        frame_start;
    logic [7:0]  frame_cmd;
    logic [15:0] frame_len;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    uart_frame_tx #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .frame_start(frame_start),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .pld_data   (pld_data),
        .pld_valid  (pld_valid),
        .pld_ready  (pld_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] pld_q[$];
    bit   pld_en  = 1'b0;
    bit   bp_mode = 1'b0;
    bit   p_fire  = 1'b0;
    bit   hold_pend = 1'b0;
    logic [7:0] hold_byte;
    int   cyc = 0;
    int   n_done = 0, n_err = 0, n_pready = 0;
    int   acc_cnt = 0, acc_first = 0, acc_last = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (hold_pend) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, hold_byte});
            end
            hold_pend = tx_valid && !tx_ready;
            hold_byte = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0)
                    check("tx_unexpected", {24'd0, tx_data}, 32'h100);
                else
                    check("tx_byte", {24'd0, tx_data},
                          {24'd0, exp_q.pop_front()});
                if (acc_cnt == 0) acc_first = cyc;
                acc_last = cyc;
                acc_cnt++;
            end
            if (frame_done) n_done++;
            if (frame_err) n_err++;
            if (pld_ready) n_pready++;
            p_fire = pld_valid && pld_ready;
        end else begin
            hold_pend = 1'b0;
            p_fire    = 1'b0;
        end
    end

    always @(posedge sys_clk) begin
        #2;
        cyc++;
        if (p_fire && pld_q.size() > 0) void'(pld_q.pop_front());
        p_fire    = 1'b0;
        pld_valid = pld_en && (pld_q.size() > 0);
        pld_data  = (pld_q.size() > 0) ? pld_q[0] : 8'h00;
        tx_ready  = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end

    function automatic logic [7:0] ref_csum(input int sum);
        logic [7:0] s;
        s = sum[7:0];
        return ~s;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start(input logic [7:0] c, input logic [15:0] l);
        frame_cmd   = c;
        frame_len   = l;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !frame_busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    int d0, e0, sum;
    logic [7:0] bp_pld[4];

    initial begin
        sys_rst_n   = 1'b0;
        frame_start = 1'b0;
        frame_cmd   = 8'h00;
        frame_len   = 16'h0000;
        pld_data    = 8'h00;
        pld_valid   = 1'b0;
        tx_ready    = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_pld_ready", {31'd0, pld_ready}, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        sys_rst_n = 1'b1;
        pld_en    = 1'b1;
        repeat (2) tick();

        // basic frame, full throughput
        d0 = n_done; e0 = n_err; acc_cnt = 0;
        pld_q.push_back(8'h01); pld_q.push_back(8'h02);
        foreach (bp_pld[i]) bp_pld[i] = 8'h00;
        exp_q = '{8'hAA, 8'h55, 8'h11, 8'h00, 8'h02, 8'h01, 8'h02, 8'hE9};
        start(8'h11, 16'd2);
        check("basic_busy", {31'd0, frame_busy}, 32'd1);
        check("basic_hdr0_valid", {31'd0, tx_valid}, 32'd1);
        check("basic_hdr0", {24'd0, tx_data}, 32'hAA);
        wait_idle("basic_complete", 50);
        check("basic_count", acc_cnt, 8);
        check("basic_back2back", acc_last - acc_first, 7);
        check("basic_done", n_done - d0, 1);
        check("basic_err", n_err - e0, 0);

        // zero length
        d0 = n_done; n_pready = 0;
        exp_q = '{8'hAA, 8'h55, 8'h30, 8'h00, 8'h00, 8'hCF};
        start(8'h30, 16'd0);
        wait_idle("zero_complete", 50);
        check("zero_pld_ready", n_pready, 0);
        check("zero_done", n_done - d0, 1);

        // backpressure with a stray start mid-frame
        d0 = n_done; e0 = n_err; bp_mode = 1'b1;
        bp_pld = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        sum = 32'h42 + 32'h04;
        exp_q = '{8'hAA, 8'h55, 8'h42, 8'h00, 8'h04};
        foreach (bp_pld[i]) begin
            pld_q.push_back(bp_pld[i]);
            exp_q.push_back(bp_pld[i]);
            sum += int'(bp_pld[i]);
        end
        exp_q.push_back(ref_csum(sum));
        start(8'h42, 16'd4);
        repeat (5) tick();
        start(8'h99, 16'd1);
        wait_idle("bp_complete", 200);
        check("bp_pld_drained", pld_q.size(), 0);
        check("bp_done", n_done - d0, 1);
        check("bp_err", n_err - e0, 0);
        bp_mode = 1'b0;
        tick();

        // oversize request
        d0 = n_done; e0 = n_err;
        start(8'h12, 16'd4097);
        check("over_err_pulse", {31'd0, frame_err}, 32'd1);
        check("over_busy", {31'd0, frame_busy}, 32'd0);
        check("over_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        check("over_err_low", {31'd0, frame_err}, 32'd0);
        repeat (4) tick();
        check("over_valid_late", {31'd0, tx_valid}, 32'd0);
        check("over_err_count", n_err - e0, 1);
        check("over_done", n_done - d0, 0);

        // payload starvation then padding
        d0 = n_done; e0 = n_err;
        pld_q.push_back(8'h10);
        exp_q = '{8'hAA, 8'h55, 8'h5A, 8'h00, 8'h04, 8'h10,
                  8'h00, 8'h00, 8'h00};
        exp_q.push_back(ref_csum(32'h5A + 32'h04 + 32'h10));
        start(8'h5A, 16'd4);
        wait_idle("to_complete", 400);
        check("to_err", n_err - e0, 1);
        check("to_done", n_done - d0, 1);

        // reset in the middle of the payload
        d0 = n_done; e0 = n_err;
        pld_q.push_back(8'h3C); pld_q.push_back(8'h4D);
        exp_q = '{8'hAA, 8'h55, 8'h21, 8'h00, 8'h08, 8'h3C, 8'h4D};
        start(8'h21, 16'd8);
        repeat (20) tick();
        check("mid_busy", {31'd0, frame_busy}, 32'd1);
        check("mid_sent", exp_q.size(), 0);
        sys_rst_n = 1'b0;
        #1;
        check("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mrst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mrst_busy", {31'd0, frame_busy}, 32'd0);
        check("mrst_pld_ready", {31'd0, pld_ready}, 32'd0);
        check("mrst_err", {31'd0, frame_err}, 32'd0);
        exp_q.delete();
        pld_q.delete();
        tick();
        sys_rst_n = 1'b1;
        tick();
        pld_q.push_back(8'h08);
        exp_q = '{8'hAA, 8'h55, 8'h77, 8'h00, 8'h01, 8'h08};
        exp_q.push_back(ref_csum(32'h77 + 32'h01 + 32'h08));
        start(8'h77, 16'd1);
        wait_idle("fresh_complete", 50);
        check("fresh_done", n_done - d0, 1);
        check("fresh_err", n_err - e0, 0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
